// File: rtl/reg_file_scoreboard.sv
// Register file with per-register busy scoreboard, 1-cycle operand return.
// Optional same-cycle writeback bypass: define RF_BYPASS_EN.
module reg_file_scoreboard #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iss_valid,
    output logic               iss_ready,
    input  logic [AW-1:0]      iss_rs1,
    input  logic [AW-1:0]      iss_rs2,
    input  logic               iss_rd_en,
    input  logic [AW-1:0]      iss_rd,
    output logic               op_valid,
    output logic [DW-1:0]      op_rs1_data,
    output logic [DW-1:0]      op_rs2_data,
    input  logic               wb_valid,
    input  logic [AW-1:0]      wb_addr,
    input  logic [DW-1:0]      wb_data,
    output logic [(1<<AW)-1:0] busy_vec
);
    localparam int NR = 1 << AW;

    logic [DW-1:0] r_regs [NR];
    logic [NR-1:0] r_busy;
    logic          r_op_valid;
    logic [DW-1:0] r_op1;
    logic [DW-1:0] r_op2;

    logic [NR-1:0] w_wb_hot;
    logic [NR-1:0] w_busy_eff;
    logic [NR-1:0] w_set;
    logic [NR-1:0] w_busy_nxt;
    logic          w_haz1;
    logic          w_haz2;
    logic          w_waw;
    logic          w_acc;
    logic [DW-1:0] w_op1;
    logic [DW-1:0] w_op2;

    always_comb begin
        w_wb_hot = '0;
        if (wb_valid && wb_addr != '0)
            w_wb_hot[wb_addr] = 1'b1;
    end

`ifdef RF_BYPASS_EN
    assign w_busy_eff = r_busy & ~w_wb_hot;
`else
    assign w_busy_eff = r_busy;
`endif

    assign w_haz1 = (iss_rs1 != '0) && w_busy_eff[iss_rs1];
    assign w_haz2 = (iss_rs2 != '0) && w_busy_eff[iss_rs2];
    assign w_waw  = iss_rd_en && (iss_rd != '0) && w_busy_eff[iss_rd];

    assign iss_ready = !(w_haz1 || w_haz2 || w_waw);
    assign w_acc     = iss_valid && iss_ready;

    always_comb begin
        w_op1 = r_regs[iss_rs1];
        w_op2 = r_regs[iss_rs2];
`ifdef RF_BYPASS_EN
        if (w_wb_hot[iss_rs1])
            w_op1 = wb_data;
        if (w_wb_hot[iss_rs2])
            w_op2 = wb_data;
`endif
        if (iss_rs1 == '0)
            w_op1 = '0;
        if (iss_rs2 == '0)
            w_op2 = '0;
    end

    // A reservation in the same cycle as a writeback to that register wins.
    always_comb begin
        w_set = '0;
        if (w_acc && iss_rd_en && iss_rd != '0)
            w_set[iss_rd] = 1'b1;
        w_busy_nxt    = (r_busy & ~w_wb_hot) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++)
                r_regs[i] <= '0;
        end else if (wb_valid && wb_addr != '0) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_op_valid <= 1'b0;
            r_op1      <= '0;
            r_op2      <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_op_valid <= w_acc;
            if (w_acc) begin
                r_op1 <= w_op1;
                r_op2 <= w_op2;
            end
        end
    end

    assign op_valid    = r_op_valid;
    assign op_rs1_data = r_op1;
    assign op_rs2_data = r_op2;
    assign busy_vec    = r_busy;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed, table-driven bench for reg_file_scoreboard.
// Expected values follow the RF_BYPASS_EN setting of the build.
module tb_reg_file_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          iss_valid;
    logic          iss_ready;
    logic [AW-1:0] iss_rs1;
    logic [AW-1:0] iss_rs2;
    logic          iss_rd_en;
    logic [AW-1:0] iss_rd;
    logic          op_valid;
    logic [DW-1:0] op_rs1_data;
    logic [DW-1:0] op_rs2_data;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [31:0]   busy_vec;

    int n_chk;
    int n_fail;

    reg_file_scoreboard #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_rd_en   (iss_rd_en),
        .iss_rd      (iss_rd),
        .op_valid    (op_valid),
        .op_rs1_data (op_rs1_data),
        .op_rs2_data (op_rs2_data),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy_vec    (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rde;
        logic [4:0]  rd;
        logic        wbv;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_o1;
        logic [31:0] e_o2;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic rde, input logic [4:0] rd,
        input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
        input logic e_rdy, input logic e_ov,
        input logic [31:0] e_o1, input logic [31:0] e_o2,
        input logic [31:0] e_busy);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rde = rde; r.rd = rd;
        r.wbv = wbv; r.wba = wba; r.wbd = wbd;
        r.e_rdy = e_rdy; r.e_ov = e_ov;
        r.e_o1 = e_o1; r.e_o2 = e_o2; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0;
        iss_rd_en = 1'b0; iss_rd = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic run_row(input vec_t r, input int idx);
        @(negedge clk);
        iss_valid = r.v; iss_rs1 = r.rs1; iss_rs2 = r.rs2;
        iss_rd_en = r.rde; iss_rd = r.rd;
        wb_valid = r.wbv; wb_addr = r.wba; wb_data = r.wbd;
        #1;
        chk($sformatf("row%0d iss_ready", idx), {31'd0, iss_ready}, {31'd0, r.e_rdy});
        @(posedge clk);
        #1;
        chk($sformatf("row%0d op_valid", idx), {31'd0, op_valid}, {31'd0, r.e_ov});
        chk($sformatf("row%0d op_rs1", idx), op_rs1_data, r.e_o1);
        chk($sformatf("row%0d op_rs2", idx), op_rs2_data, r.e_o2);
        chk($sformatf("row%0d busy", idx), busy_vec, r.e_busy);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        idle();
        rst_n = 1'b0;

        // wb then read; RAW on r7; WAW on r3
        vecs.push_back(mk(0,0,0,0,0, 1,5,32'hDEADBEEF, 1,0,0,0,0));
        vecs.push_back(mk(1,5,0,0,0, 0,0,0, 1,1,32'hDEADBEEF,0,0));
        vecs.push_back(mk(1,0,0,1,7, 0,0,0, 1,1,0,0,32'h80));
        vecs.push_back(mk(1,7,0,0,0, 0,0,0, 0,0,0,0,32'h80));
`ifdef RF_BYPASS_EN
        vecs.push_back(mk(1,7,0,0,0, 1,7,32'h1234, 1,1,32'h1234,0,0));
`else
        vecs.push_back(mk(1,7,0,0,0, 1,7,32'h1234, 0,0,0,0,0));
`endif
        vecs.push_back(mk(1,7,0,0,0, 0,0,0, 1,1,32'h1234,0,0));
        vecs.push_back(mk(1,0,0,1,3, 0,0,0, 1,1,0,0,32'h8));
        vecs.push_back(mk(1,0,0,1,3, 0,0,0, 0,0,0,0,32'h8));
`ifdef RF_BYPASS_EN
        vecs.push_back(mk(1,0,0,1,3, 1,3,32'h55, 1,1,0,0,32'h8));
`else
        vecs.push_back(mk(1,0,0,1,3, 1,3,32'h55, 0,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,3, 0,0,0, 1,1,0,0,32'h8));
`endif
        vecs.push_back(mk(0,0,0,0,0, 1,3,32'h55, 1,0,0,0,0));
        // r0 is never written or reserved
        vecs.push_back(mk(0,0,0,0,0, 1,0,32'hFFFF, 1,0,0,0,0));
        vecs.push_back(mk(1,0,3,0,0, 0,0,0, 1,1,0,32'h55,0));
        vecs.push_back(mk(1,0,0,1,0, 0,0,0, 1,1,0,0,0));
        // back-to-back reads
        vecs.push_back(mk(0,0,0,0,0, 1,1,32'h11, 1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1,2,32'h22, 1,0,0,0,0));
        vecs.push_back(mk(1,1,2,0,0, 0,0,0, 1,1,32'h11,32'h22,0));
        vecs.push_back(mk(1,2,3,0,0, 0,0,0, 1,1,32'h22,32'h55,0));
        vecs.push_back(mk(1,3,1,0,0, 0,0,0, 1,1,32'h55,32'h11,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0, 1,0,32'h55,32'h11,0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset op_valid", {31'd0, op_valid}, 32'd0);
        chk("reset busy", busy_vec, 32'd0);
        chk("reset op_rs1", op_rs1_data, 32'd0);
        chk("reset iss_ready", {31'd0, iss_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_row(vecs[i], i);

        // async reset while an operand pulse and a reservation are live
        @(negedge clk);
        iss_valid = 1'b1; iss_rs1 = 5'd1; iss_rs2 = 5'd2;
        iss_rd_en = 1'b1; iss_rd = 5'd9;
        @(posedge clk);
        #1;
        chk("pre-rst op_valid", {31'd0, op_valid}, 32'd1);
        chk("pre-rst op_rs1", op_rs1_data, 32'h11);
        chk("pre-rst busy", busy_vec, 32'h200);
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst op_valid", {31'd0, op_valid}, 32'd0);
        chk("rst busy", busy_vec, 32'd0);
        chk("rst op_rs1", op_rs1_data, 32'd0);
        chk("rst op_rs2", op_rs2_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        iss_valid = 1'b1; iss_rs1 = 5'd1; iss_rs2 = 5'd9;
        #1;
        chk("post-rst iss_ready", {31'd0, iss_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("post-rst op_valid", {31'd0, op_valid}, 32'd1);
        chk("post-rst op_rs1", op_rs1_data, 32'd0);
        idle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

- Register-file responder at the far end of the instruction decoder's source-register selects.
- Accepts an issue request carrying rs1/rs2 addresses and an optional destination reservation.
- Returns both operands one cycle later and tracks pending writes with a per-register busy scoreboard.
- Stalls issue on RAW/WAW hazards until the matching writeback arrives.

## Interface

Parameters:
- DW, 32, data width of each register.
- AW, 5, register address width (2^AW registers; register 0 hardwired to zero).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- iss_valid  input  1  issue request present.
- iss_ready  output  1  issue may be accepted this cycle (combinational).
- iss_rs1  input  AW  source register 1 address.
- iss_rs2  input  AW  source register 2 address.
- iss_rd_en  input  1  request reserves a destination.
- iss_rd  input  AW  destination register to reserve.
- op_valid  output  1  operands valid; one-cycle pulse.
- op_rs1_data  output  DW  operand 1.
- op_rs2_data  output  DW  operand 2.
- wb_valid  input  1  writeback present; always accepted.
- wb_addr  input  AW  writeback register.
- wb_data  input  DW  writeback data.
- busy_vec  output  2^AW  current scoreboard; bit 0 always 0.

## Operation

- State: register array regs[1..2^AW-1]; busy bit per register.
- Handshake: an issue is accepted when iss_valid && iss_ready at a rising edge.
- Hazard, src = rs1 or rs2: busy[src], src != 0, not cleared this cycle (see Configuration).
- Hazard, WAW: iss_rd_en && busy[iss_rd] && iss_rd != 0 && not cleared this cycle.
- iss_ready = no source hazard and no WAW hazard; independent of iss_valid.
- On accept:
  - Capture operands into op_rs*_data.
  - Assert op_valid next cycle.
  - If iss_rd_en && iss_rd != 0, set busy[iss_rd].
  - Operand for address 0 is always 0.
- Writeback with wb_addr != 0:
  - Writes regs[wb_addr] and clears busy[wb_addr].
  - Writes even when the register is not busy; busy stays 0.
  - wb_addr = 0 is ignored.
- Same-cycle writeback and reservation of the same register:
  - Data is written.
  - Busy ends at 1 (new reservation wins).
- Unaccepted cycle: op_rs*_data hold their last value; op_valid = 0.
- At most one outstanding write per register (guaranteed by the WAW stall).

## Timing

- Operand latency: 1 cycle from accept edge to op_valid high.
- Writeback visibility: the array is updated at the wb edge.
  - A read accepted in a later cycle sees the new data.
  - Same-cycle visibility depends on RF_BYPASS_EN.
- Back-to-back accepts are allowed every cycle; op_valid stays high continuously.
- Reset (asynchronous, any time):
  - All regs, all busy bits, op_rs1_data and op_rs2_data go to 0.
  - op_valid goes to 0.
  - An in-flight operand pulse is dropped.
  - The first accept after rst_n deasserts is handled normally.
- iss_ready after reset: 1.

## Configuration

RF_BYPASS_EN defined:
- A writeback in the accept cycle clears that register's hazard combinationally.
- A source matching wb_addr (non-zero) captures wb_data instead of the array value.
- RAW stall ends in the writeback cycle.

RF_BYPASS_EN undefined:
- Hazards use registered busy only.
- A source matching a same-cycle writeback stalls that cycle and is accepted the next cycle, reading the array.
- RAW costs one extra cycle.

## Test plan

- Reset, wb (5, 0xDEADBEEF), then issue rs1=5, rs2=0 → next cycle op_valid=1, op_rs1_data=0xDEADBEEF, op_rs2_data=0.
- Issue rd_en=1, rd=7 → busy_vec[7]=1.
  - Issue rs1=7 → iss_ready=0 until wb (7, 0x1234).
  - With RF_BYPASS_EN: accepted in the wb cycle with data 0x1234.
  - Without RF_BYPASS_EN: accepted one cycle later with data 0x1234.
- Reserve rd=3, then issue rd_en=1, rd=3 → WAW stall.
  - Same-cycle wb (3, 0x55) with bypass → accepted; busy_vec[3] remains 1; regs[3]=0x55.
- wb (0, 0xFFFF) then issue rs1=0 → operand 0.
  - Issue rd_en=1, rd=0 → busy_vec stays all 0.
- Back-to-back issues rs1=1,2,3 over three cycles with no hazards → op_valid high three consecutive cycles with the matching data.
- Reserve rd=9, assert rst_n=0 mid-pulse → op_valid, busy_vec, and both operands read 0 immediately; iss_ready=1 after release.
